clk_frac_monitor: RTL and testbench



---
 rtl/clk_frac_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_clk_frac_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_frac_monitor.sv
// clk_frac_monitor: checks a fractional-divider strobe stream against SOURCE_NUM clocks per DEST_NUM intervals.
// Define CLK_FRAC_MON_MINMAX_EN to add per-window minimum/maximum interval outputs.
module clk_frac_monitor #(
    parameter int unsigned SOURCE_NUM = 76,
    parameter int unsigned DEST_NUM   = 10,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_WIN   = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frac_in,
    input  logic             clr,
    output logic [CNT_W-1:0] meas_total,
    output logic             meas_valid,
    output logic             meas_ok,
    output logic             locked,
    output logic             err
`ifdef CLK_FRAC_MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] ivl_min,
    output logic [CNT_W-1:0] ivl_max
`endif
);

    localparam int unsigned DIV_LO  = SOURCE_NUM / DEST_NUM;
    localparam int unsigned DIV_HI  = DIV_LO + 1;
    localparam int unsigned TIMEOUT = 2 * DIV_HI;
    localparam int unsigned OK_LO   = (SOURCE_NUM > TOL) ? SOURCE_NUM - TOL : 0;
    localparam int unsigned OK_HI   = SOURCE_NUM + TOL;
    localparam int unsigned IDX_W   = $clog2(DEST_NUM + 1);
    localparam int unsigned RUN_W   = $clog2(LOCK_WIN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ivl_cnt_q, ivl_cnt_d;
    logic [CNT_W-1:0] win_sum_q, win_sum_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] meas_total_d;
    logic             meas_valid_d, meas_ok_d, locked_d, err_d;

    logic [CNT_W-1:0] ivl;
    logic [CNT_W:0]   sum_ext;
    logic [CNT_W-1:0] sum_sat;
    logic             ivl_bad, sum_ok;

`ifdef CLK_FRAC_MON_MINMAX_EN
    logic [CNT_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [CNT_W-1:0] ivl_min_d, ivl_max_d, cur_min, cur_max;
`endif

    // Interval closed by a strobe this cycle, and the saturated window sum including it
    always_comb begin
        ivl     = (ivl_cnt_q == '1) ? ivl_cnt_q : ivl_cnt_q + CNT_W'(1);
        sum_ext = {1'b0, win_sum_q} + {1'b0, ivl};
        sum_sat = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
        ivl_bad = (32'(ivl) != DIV_LO) && (32'(ivl) != DIV_HI);
        sum_ok  = (32'(sum_sat) >= OK_LO) && (32'(sum_sat) <= OK_HI);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        ivl_cnt_d    = ivl_cnt_q;
        win_sum_d    = win_sum_q;
        win_idx_d    = win_idx_q;
        run_d        = run_q;
        meas_total_d = meas_total;
        meas_valid_d = 1'b0;
        meas_ok_d    = meas_ok;
        locked_d     = locked;
        err_d        = err;
`ifdef CLK_FRAC_MON_MINMAX_EN
        run_min_d    = run_min_q;
        run_max_d    = run_max_q;
        ivl_min_d    = ivl_min;
        ivl_max_d    = ivl_max;
        cur_min      = (ivl < run_min_q) ? ivl : run_min_q;
        cur_max      = (ivl > run_max_q) ? ivl : run_max_q;
`endif

        if (clr) begin
            state_d      = IDLE;
            ivl_cnt_d    = '0;
            win_sum_d    = '0;
            win_idx_d    = '0;
            run_d        = '0;
            meas_total_d = '0;
            meas_ok_d    = 1'b0;
            locked_d     = 1'b0;
            err_d        = 1'b0;
`ifdef CLK_FRAC_MON_MINMAX_EN
            run_min_d    = '1;
            run_max_d    = '0;
            ivl_min_d    = '1;
            ivl_max_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ivl_cnt_d = '0;
                    if (frac_in) begin
                        state_d   = MEAS;
                        win_sum_d = '0;
                        win_idx_d = '0;
`ifdef CLK_FRAC_MON_MINMAX_EN
                        run_min_d = '1;
                        run_max_d = '0;
`endif
                    end
                end
                MEAS: begin
                    if (frac_in) begin
                        ivl_cnt_d = '0;
                        if (ivl_bad) begin
                            err_d    = 1'b1;
                            run_d    = '0;
                            locked_d = 1'b0;
                        end
                        if (win_idx_q == IDX_W'(DEST_NUM - 1)) begin
                            // Closing strobe also opens the next window
                            win_sum_d    = '0;
                            win_idx_d    = '0;
                            meas_total_d = sum_sat;
                            meas_valid_d = 1'b1;
                            meas_ok_d    = sum_ok;
                            if (sum_ok && !ivl_bad) begin
                                run_d    = (32'(run_q) >= LOCK_WIN) ? run_q : run_q + RUN_W'(1);
                                locked_d = (32'(run_d) == LOCK_WIN);
                            end else begin
                                run_d    = '0;
                                locked_d = 1'b0;
                            end
`ifdef CLK_FRAC_MON_MINMAX_EN
                            ivl_min_d = cur_min;
                            ivl_max_d = cur_max;
                            run_min_d = '1;
                            run_max_d = '0;
`endif
                        end else begin
                            win_sum_d = sum_sat;
                            win_idx_d = win_idx_q + IDX_W'(1);
`ifdef CLK_FRAC_MON_MINMAX_EN
                            run_min_d = cur_min;
                            run_max_d = cur_max;
`endif
                        end
                    end else if (32'(ivl_cnt_q) == TIMEOUT - 1) begin
                        // Strobes stopped: drop the partial window and wait for a fresh start
                        state_d   = IDLE;
                        ivl_cnt_d = '0;
                        win_sum_d = '0;
                        win_idx_d = '0;
                        run_d     = '0;
                        locked_d  = 1'b0;
                        err_d     = 1'b1;
                    end else begin
                        ivl_cnt_d = ivl;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ivl_cnt_q  <= '0;
            win_sum_q  <= '0;
            win_idx_q  <= '0;
            run_q      <= '0;
            meas_total <= '0;
            meas_valid <= 1'b0;
            meas_ok    <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
`ifdef CLK_FRAC_MON_MINMAX_EN
            run_min_q  <= '1;
            run_max_q  <= '0;
            ivl_min    <= '1;
            ivl_max    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ivl_cnt_q  <= ivl_cnt_d;
            win_sum_q  <= win_sum_d;
            win_idx_q  <= win_idx_d;
            run_q      <= run_d;
            meas_total <= meas_total_d;
            meas_valid <= meas_valid_d;
            meas_ok    <= meas_ok_d;
            locked     <= locked_d;
            err        <= err_d;
`ifdef CLK_FRAC_MON_MINMAX_EN
            run_min_q  <= run_min_d;
            run_max_q  <= run_max_d;
            ivl_min    <= ivl_min_d;
            ivl_max    <= ivl_max_d;
`endif
        end
    end

endmodule

// File: tb/tb_clk_frac_monitor.sv
// Directed bench for clk_frac_monitor: reference model pushes expected windows, monitor pops them on meas_valid.
module tb_clk_frac_monitor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       frac_in;
    logic       clr;
    logic [7:0] meas_total;
    logic       meas_valid;
    logic       meas_ok;
    logic       locked;
    logic       err;
`ifdef CLK_FRAC_MON_MINMAX_EN
    logic [7:0] ivl_min;
    logic [7:0] ivl_max;
`endif

    clk_frac_monitor dut (
        .clk        (clk),
        .rstn       (rstn),
        .frac_in    (frac_in),
        .clr        (clr),
        .meas_total (meas_total),
        .meas_valid (meas_valid),
        .meas_ok    (meas_ok),
        .locked     (locked),
        .err        (err)
`ifdef CLK_FRAC_MON_MINMAX_EN
        ,
        .ivl_min    (ivl_min),
        .ivl_max    (ivl_max)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] total;
        logic       ok;
        logic       lck;
        logic [7:0] mn;
        logic [7:0] mx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   pat[10]  = '{8, 8, 7, 8, 7, 8, 8, 7, 8, 7};

    // Reference model state
    bit   m_meas;
    bit   m_err;
    int   m_idx, m_sum, m_run, m_mn, m_mx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_meas = 1'b0;
        m_err  = 1'b0;
        m_idx  = 0;
        m_sum  = 0;
        m_run  = 0;
        m_mn   = 255;
        m_mx   = 0;
    endtask

    task automatic model_timeout();
        m_meas = 1'b0;
        m_err  = 1'b1;
        m_run  = 0;
    endtask

    // Idle n-1 cycles, then one strobe cycle; the model pushes a result when a window closes
    task automatic strobe(input int n);
        bit ok;
        bit bad;
        for (int i = 1; i < n; i++) tick();
        if (m_meas) begin
            bad = (n != 7) && (n != 8);
            if (bad) begin
                m_run = 0;
                m_err = 1'b1;
            end
            m_sum = (m_sum + n > 255) ? 255 : m_sum + n;
            if (n < m_mn) m_mn = n;
            if (n > m_mx) m_mx = n;
            m_idx++;
            if (m_idx == 10) begin
                ok = (m_sum == 76);
                if (ok && !bad) m_run = (m_run >= 4) ? 4 : m_run + 1;
                else            m_run = 0;
                sb.push_back('{total: 8'(m_sum), ok: ok, lck: (m_run == 4),
                               mn: 8'(m_mn), mx: 8'(m_mx)});
                m_idx = 0;
                m_sum = 0;
                m_mn  = 255;
                m_mx  = 0;
            end
        end else begin
            m_meas = 1'b1;
            m_idx  = 0;
            m_sum  = 0;
            m_mn   = 255;
            m_mx   = 0;
        end
        frac_in = 1'b1;
        tick();
        frac_in = 1'b0;
    endtask

    task automatic ideal_window();
        for (int i = 0; i < 10; i++) strobe(pat[i]);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_total"}, 32'(meas_total), 32'd0);
        chk({tag, "_valid"}, 32'(meas_valid), 32'd0);
        chk({tag, "_ok"},    32'(meas_ok),    32'd0);
        chk({tag, "_locked"},32'(locked),     32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
`ifdef CLK_FRAC_MON_MINMAX_EN
        chk({tag, "_min"},   32'(ivl_min),    32'd255);
        chk({tag, "_max"},   32'(ivl_max),    32'd0);
`endif
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    // Scoreboard: every meas_valid pulse must match the oldest predicted window
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("valid_unexpected", 32'(meas_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("meas_total", 32'(meas_total), 32'(e.total));
                chk("meas_ok",    32'(meas_ok),    32'(e.ok));
                chk("locked",     32'(locked),     32'(e.lck));
`ifdef CLK_FRAC_MON_MINMAX_EN
                chk("ivl_min",    32'(ivl_min),    32'(e.mn));
                chk("ivl_max",    32'(ivl_max),    32'(e.mx));
`endif
            end
        end
    end

    initial begin
        rstn    = 1'b0;
        frac_in = 1'b0;
        clr     = 1'b0;
        model_clear();
        repeat (3) tick();
        check_cleared("reset");
        rstn = 1'b1;
        tick();

        // Ideal 76/10 stream: lock on the 4th window
        strobe(1);
        repeat (6) ideal_window();
        chk("ideal_err",    32'(err),    32'(m_err));
        chk("ideal_locked", 32'(locked), 32'd1);

        // Constant interval 8: total 80, never ok, no interval error
        do_clr();
        check_cleared("clr");
        strobe(1);
        repeat (3) for (int i = 0; i < 10; i++) strobe(8);
        chk("const8_err",    32'(err),    32'(m_err));
        chk("const8_locked", 32'(locked), 32'd0);

        // Interval of 5 inside a locked stream
        do_clr();
        strobe(1);
        repeat (4) ideal_window();
        chk("pre_bad_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 10; i++) begin
            strobe((i == 0) ? 5 : pat[i]);
            if (i == 0) begin
                chk("bad_ivl_err",    32'(err),    32'd1);
                chk("bad_ivl_locked", 32'(locked), 32'd0);
            end
        end
        repeat (4) ideal_window();
        chk("relock_locked", 32'(locked), 32'd1);
        chk("sticky_err",    32'(err),    32'(m_err));

        // Strobes stop after lock: timeout after 16 silent cycles
        do_clr();
        strobe(1);
        repeat (4) ideal_window();
        repeat (15) tick();
        chk("pre_timeout_err",    32'(err),    32'd0);
        chk("pre_timeout_locked", 32'(locked), 32'd1);
        tick();
        model_timeout();
        chk("timeout_err",    32'(err),    32'(m_err));
        chk("timeout_locked", 32'(locked), 32'd0);
        chk("timeout_total",  32'(meas_total), 32'd76);
        repeat (5) tick();
        strobe(1);
        ideal_window();
        chk("resume_err", 32'(err), 32'(m_err));

        // clr together with a mid-window strobe
        do_clr();
        strobe(1);
        repeat (4) ideal_window();
        for (int i = 0; i < 3; i++) strobe(pat[i]);
        for (int i = 1; i < pat[3]; i++) tick();
        frac_in = 1'b1;
        clr     = 1'b1;
        tick();
        frac_in = 1'b0;
        clr     = 1'b0;
        model_clear();
        check_cleared("clr_strobe");
        repeat (4) tick();
        strobe(1);
        ideal_window();

        // Asynchronous reset mid-window
        repeat (3) ideal_window();
        chk("pre_rst_locked", 32'(locked), 32'd1);
        strobe(pat[0]);
        strobe(pat[1]);
        tick();
        #1;
        rstn = 1'b0;
        #1;
        model_clear();
        check_cleared("async_rst");
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        strobe(1);
        repeat (4) ideal_window();
        chk("post_rst_locked", 32'(locked), 32'd1);
        chk("post_rst_err",    32'(err),    32'(m_err));

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
